mult_seq: RTL and testbench
===========================

# mult_seq

Parametrised sequential shift-add multiplier producing a full 2·WIDTH-bit product, with selectable signed or unsigned operation per request. It is the successor to the fixed 32-bit unsigned multiplier and sits beside the ALU. The datapath is driven through a start/busy/done handshake. Latency is fixed and independent of operand values and mode.

## Interface
- WIDTH, 32: operand width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request; sampled only when the block is not busy.
- is_signed  in  1  1 = two's-complement operands; 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while a multiply is in progress.
- done  out  1  high once the result is valid; held until the next accepted start or reset.
- prod_hi  out  WIDTH  upper half of the product.
- prod_lo  out  WIDTH  lower half of the product.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE/DONE → RUN on start=1:
  - latch |a| into the multiplicand register and |b| into prod_lo.
  - clear prod_hi.
  - latch neg = is_signed & (a[MSB] ^ b[MSB]).
  - load the iteration counter with WIDTH.
  - Magnitudes are taken only when is_signed=1.
- RUN, each cycle:
  - if prod_lo[0]=1, add the multiplicand to prod_hi; otherwise add 0.
  - shift {carry, sum, prod_lo} right by 1. The adder carry-out MUST enter bit 2·WIDTH-1; it is never dropped.
  - decrement the counter. When the counter reaches 1, go to FIX.
- FIX: if neg=1, replace {prod_hi, prod_lo} with its two's-complement negation; otherwise leave it unchanged. Go to DONE.
- DONE: done=1. Outputs hold until start is accepted.
- Arithmetic:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as an unsigned WIDTH-bit value.
  - The adder is WIDTH+1 bits wide (sum plus carry).
  - The full product always fits in 2·WIDTH bits; there is no overflow flag.
- Boundary conditions:
  - start while busy: ignored. The operation in flight and its operands are unaffected.
  - start in DONE: accepted. done drops and busy rises at the same edge.
  - Zero operand: runs the full iteration count and produces 0. Signed zero results are never negative, so negating 0 yields 0.
  - reset asserted at any time, including mid-RUN: state goes to IDLE immediately and all registers clear.

## Timing
- Reset values: busy=0, done=0, prod_hi=0, prod_lo=0, state IDLE.
- Edge E0 (start accepted): busy=1 and done=0 after E0.
- Edges E1..EWIDTH: iterations.
- Edge E(WIDTH+1): FIX completes. done=1 and busy=0 after this edge; the product is valid in the same cycle.
- Latency is WIDTH+1 cycles from the accepting edge to done, for both modes.
- Back-to-back throughput: start may be asserted in the first done cycle, giving one result every WIDTH+2 cycles.
- busy and done are never high together. Both are low only in IDLE.
- prod_hi and prod_lo change during RUN and are not meaningful while busy=1.

## Structure
- Shared package mult_pkg holds:
  - state enum mult_state_t {IDLE, RUN, FIX, DONE};
  - counter width localparam, CNT_W = $clog2(WIDTH+1).
- One sub-module: add_n, a parametrised WIDTH-bit adder with carry-in, carry-out and sum. The FSM, counter, shift and negation logic stay in mult_seq.

## Test plan
- WIDTH=32, unsigned, 3 × 5 → {hi,lo} = 0x00000000_0000000F; done asserted exactly 33 cycles after the accepting edge.
- WIDTH=32, unsigned, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001. This checks carry propagation.
- WIDTH=32, signed:
  - -3 × 5 → 0xFFFFFFFF_FFFFFFF1;
  - -1 × -1 → 0x00000000_00000001;
  - 0x80000000 × 0x80000000 → 0x40000000_00000000.
- Start re-asserted on every cycle of RUN with different operands → the first result is unchanged. A start in the done cycle is accepted and its result appears 33 cycles later.
- reset pulsed low at RUN iteration 10 → busy, done and the product go to 0 immediately. A following 7 × 6 → 42 with normal latency.
- WIDTH=8:
  - signed 0x80 × 0x7F → 0xC080;
  - unsigned 0xFF × 0xFF → 0xFE01;
  - done asserted 9 cycles after the accepting edge.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_t : FSM state encoding (IDLE, RUN, FIX, DONE)
//   MAX_WIDTH    : widest operand the multiplier is built for
//   CNT_W        : iteration counter width. It is sized for MAX_WIDTH so it
//                  can hold any legal WIDTH, including WIDTH itself at load.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  localparam int MAX_WIDTH = 64;
  localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

endpackage

// File: rtl/mult_seq_add.sv
// add_n: parametrised WIDTH-bit ripple adder with carry-in and carry-out.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry-in
//   sum   out WIDTH  low WIDTH bits of a + b + cin
//   cout  out 1      carry-out (bit WIDTH of the full sum)
module add_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, full 2*WIDTH-bit product,
// signed or unsigned per request. Operands are reduced to magnitudes, the
// unsigned product is formed over WIDTH iterations, and a final FIX cycle
// negates the result when the operand signs differ.
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-low reset
//   start      in  1      request, honoured only when not busy
//   is_signed  in  1      1 = two's-complement operands
//   a, b       in  WIDTH  multiplicand / multiplier
//   busy       out 1      multiply in progress (RUN or FIX)
//   done       out 1      result valid, held until next accepted start
//   prod_hi    out WIDTH  upper half of the product
//   prod_lo    out WIDTH  lower half of the product
// Latency: WIDTH+1 cycles from the accepting edge to done.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  mult_state_t      state;
  mult_state_t      state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             accept;
  logic [2*WIDTH-1:0] prod_neg;

  // Two's-complement magnitude. The most negative value maps onto
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic             take);
    logic [WIDTH-1:0] r;
    r = v;
    if (take && v[WIDTH-1]) r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    return r;
  endfunction

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign addend   = prod_lo[0] ? mcand : '0;
  assign prod_neg = ~{prod_hi, prod_lo} + {{(2*WIDTH-1){1'b0}}, 1'b1};

  add_n #(.WIDTH(WIDTH)) u_add (
    .a    (prod_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // The counter still reads 1 during the last iteration.
        if (cnt == CNT_W'(1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand   <= mag(a, is_signed);
            prod_lo <= mag(b, is_signed);
            prod_hi <= '0;
            neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt     <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          // Carry-out lands in the top bit so the full sum survives the shift.
          {prod_hi, prod_lo} <= {cout, sum, prod_lo[WIDTH-1:1]};
          cnt                <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (neg) {prod_hi, prod_lo} <= prod_neg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: one WIDTH=32 and one WIDTH=8 instance. Stimulus pushes
// expected products (from plain wide-integer arithmetic) into per-instance
// queues; monitors pop and compare on each rising edge of done.
module tb_mult_seq;

  typedef struct {
    logic [127:0] exp;
    int           acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  logic        start32, sgn32, busy32, done32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;

  exp_t q32[$];
  exp_t q8[$];
  logic done32_prev;
  logic done8_prev;

  mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .a(a32), .b(b32), .busy(busy32), .done(done32),
    .prod_hi(hi32), .prod_lo(lo32)
  );

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .prod_hi(hi8), .prod_lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sign- or zero-extend to 128 bits, multiply, keep 2*w bits.
  function automatic logic [127:0] ref_prod(int w, logic [63:0] x,
                                            logic [63:0] y, logic s);
    logic [127:0] ex, ey, m;
    ex = {64'd0, x};
    ey = {64'd0, y};
    if (s && x[w-1]) ex = ex | (~128'd0 << w);
    if (s && y[w-1]) ey = ey | (~128'd0 << w);
    m = (128'd1 << (2 * w)) - 128'd1;
    return (ex * ey) & m;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors.
  initial begin
    done32_prev = 1'b0;
    done8_prev  = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_excl32", {127'd0, busy32 & done32}, 128'd0);
    if (done32 && !done32_prev) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 128'd1, 128'd0);
      end else begin
        e = q32.pop_front();
        chk("prod32", {64'd0, hi32, lo32}, e.exp);
        chk("latency32", 128'(cyc - e.acc), 128'd33);
      end
    end
    done32_prev = done32;
  end

  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_excl8", {127'd0, busy8 & done8}, 128'd0);
    if (done8 && !done8_prev) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 128'd1, 128'd0);
      end else begin
        e = q8.pop_front();
        chk("prod8", {112'd0, hi8, lo8}, e.exp);
        chk("latency8", 128'(cyc - e.acc), 128'd9);
      end
    end
    done8_prev = done8;
  end

  task automatic wait_idle32();
    int g;
    g = 0;
    while (busy32 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("timeout_idle32", 128'd1, 128'd0);
  endtask

  task automatic issue32(logic [31:0] x, logic [31:0] y, logic s);
    exp_t e;
    @(negedge clk);
    wait_idle32();
    start32 = 1'b1; a32 = x; b32 = y; sgn32 = s;
    e.exp = ref_prod(32, {32'd0, x}, {32'd0, y}, s);
    e.acc = cyc + 1;
    q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
    chk("accept32_busy_done", {126'd0, busy32, done32}, 128'd2);
  endtask

  task automatic issue8(logic [7:0] x, logic [7:0] y, logic s);
    exp_t e;
    int g;
    @(negedge clk);
    g = 0;
    while (busy8 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("timeout_idle8", 128'd1, 128'd0);
    start8 = 1'b1; a8 = x; b8 = y; sgn8 = s;
    e.exp = ref_prod(8, {56'd0, x}, {56'd0, y}, s);
    e.acc = cyc + 1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    chk("accept8_busy_done", {126'd0, busy8, done8}, 128'd2);
  endtask

  // Keep start high with junk operands for the whole run; the request
  // presented in the first done cycle is a real one and must be accepted.
  task automatic hammer32();
    exp_t e;
    int g;
    issue32(32'd3, 32'd5, 1'b0);
    g = 0;
    while (!done32 && g < 200) begin
      start32 = 1'b1;
      a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom_range(0, 1));
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("timeout_hammer32", 128'd1, 128'd0);
    a32 = 32'hFFFF_FFF9; b32 = 32'd1234; sgn32 = 1'b1;
    e.exp = ref_prod(32, {32'd0, a32}, {32'd0, b32}, 1'b1);
    e.acc = cyc + 1;
    q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
    chk("accept_in_done32", {126'd0, busy32, done32}, 128'd2);
  endtask

  initial begin
    int g;
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(negedge clk);
    chk("reset32", {62'd0, busy32, done32, hi32, lo32}, 128'd0);
    chk("reset8",  {110'd0, busy8, done8, hi8, lo8}, 128'd0);
    reset = 1'b1;

    issue32(32'd3, 32'd5, 1'b0);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue32(32'hFFFF_FFFD, 32'd5, 1'b1);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue32(32'h8000_0000, 32'h8000_0000, 1'b1);
    issue32(32'h8000_0000, 32'd1, 1'b1);
    issue32(32'd0, 32'hFFFF_FFFB, 1'b1);
    issue32(32'h1234_5678, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      issue32($urandom, $urandom, 1'($urandom_range(0, 1)));

    hammer32();

    // Reset in the middle of a run.
    issue32(32'd100, 32'd200, 1'b0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrun_reset32", {62'd0, busy32, done32, hi32, lo32}, 128'd0);
    q32.delete();
    @(negedge clk);
    reset = 1'b1;
    issue32(32'd7, 32'd6, 1'b0);

    issue8(8'h80, 8'h7F, 1'b1);
    issue8(8'hFF, 8'hFF, 1'b0);
    issue8(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 8; i++)
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));

    g = 0;
    while ((q32.size() != 0 || q8.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("timeout_drain", 128'd1, 128'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
